// File: rtl/soc_system_pio_pkg.sv
// Shared register map and capture-mode encoding for the system status PIO.
// Also holds the per-bit edge-detect helper used by the top level.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum int {
        EDGE_NONE    = 0,
        EDGE_RISING  = 1,
        EDGE_FALLING = 2,
        EDGE_ANY     = 3
    } edge_type_e;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Vectors are passed at full bus width; callers keep the low WIDTH bits.
    function automatic logic [31:0] edge_vec(input logic [31:0] cur,
                                             input logic [31:0] prev,
                                             input int          edge_type);
        logic [31:0] rise;
        logic [31:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (edge_type)
            EDGE_RISING:  return rise;
            EDGE_FALLING: return fall;
            EDGE_ANY:     return rise | fall;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-flop synchroniser bringing asynchronous status inputs into the clk domain.
// The last stage is the synchronised data used by the rest of the block.
module soc_system_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_data_sync
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_data_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_status_pio.sv
// Avalon-MM status PIO: synchronised inputs, edge capture with write-1-to-clear,
// interrupt mask and a registered interrupt request.
module soc_system_status_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1,
    parameter int IRQ_MODE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_data_sync;
    logic [WIDTH-1:0] w_edges;
    logic [WIDTH-1:0] w_clear;
    logic [31:0]      w_edge_full;
    logic [31:0]      w_rd_mux;
    logic             w_wr_mask;
    logic             w_wr_w1c;
    logic             w_irq_next;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;

    soc_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_async     (in_port),
        .o_data_sync (w_data_sync)
    );

    assign w_edge_full = edge_vec(32'(w_data_sync), 32'(r_prev), EDGE_TYPE);
    assign w_edges     = w_edge_full[WIDTH-1:0];
    assign w_wr_mask   = chipselect & write & (address == ADDR_IRQMASK);
    assign w_wr_w1c    = chipselect & write & (address == ADDR_EDGECAP);
    assign w_clear     = w_wr_w1c ? writedata[WIDTH-1:0] : '0;

    assign w_irq_next  = (IRQ_MODE == IRQ_EDGE) ? |(r_edgecap & r_irqmask)
                                                : |(w_data_sync & r_irqmask);

    // NOTE: default first so no path through the case leaves w_rd_mux unassigned (no latch).
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data_sync;
            ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:      w_rd_mux = '0;
        endcase
    end

    // A new edge wins over a coincident clear, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= '0;
            r_edgecap <= '0;
            r_irqmask <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            r_prev    <= w_data_sync;
            r_edgecap <= (r_edgecap & ~w_clear) | w_edges;
            if (w_wr_mask) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            readdata  <= w_rd_mux;
            irq       <= w_irq_next;
        end
    end

endmodule

// File: tb/tb_soc_system_status_pio.sv
// Self-checking bench: per-cycle vector tables run against three parameterisations,
// with expected outputs queued at drive time and compared after the clock edge.
module tb_soc_system_status_pio;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  din;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [7:0]  din_a = '0;
    logic [7:0]  din_b = '0;
    logic [7:0]  din_c = '0;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    soc_system_status_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(1)) u_dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(din_a), .readdata(rd_a), .irq(irq_a));

    soc_system_status_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(3), .IRQ_MODE(0)) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(din_b), .readdata(rd_b), .irq(irq_b));

    soc_system_status_pio #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(0), .IRQ_MODE(1)) u_dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(din_c), .readdata(rd_c), .irq(irq_c));

    function automatic vec_t mk(input logic rst, input logic cs, input logic wr,
                                input logic [1:0] a, input logic [31:0] wd,
                                input logic [7:0] din, input logic [31:0] er,
                                input logic ei);
        vec_t v;
        v.rst = rst; v.cs = cs; v.wr = wr; v.addr = a; v.wdata = wd;
        v.din = din; v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Each row is driven after a falling edge and its outputs judged after the next rising edge.
    task automatic run_table(input int sel, input string tag);
        vec_t        v;
        exp_t        e;
        logic [31:0] act_rd;
        logic        act_irq;
        for (int i = 0; i < tbl.size(); i++) begin
            v          = tbl[i];
            reset      = v.rst;
            chipselect = v.cs;
            write      = v.wr;
            address    = v.addr;
            writedata  = v.wdata;
            case (sel)
                0:       din_a = v.din;
                1:       din_b = v.din;
                default: din_c = v.din;
            endcase
            sb.push_back('{v.exp_rd, v.exp_irq, i});
            @(posedge clk);
            @(negedge clk);
            case (sel)
                0:       begin act_rd = rd_a; act_irq = irq_a; end
                1:       begin act_rd = rd_b; act_irq = irq_b; end
                default: begin act_rd = rd_c; act_irq = irq_c; end
            endcase
            if (sb.size() == 0) begin
                check($sformatf("%s[%0d].scoreboard_empty", tag, i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s[%0d].readdata", tag, e.idx), act_rd, e.rd);
                check($sformatf("%s[%0d].irq", tag, e.idx), {31'd0, act_irq}, {31'd0, e.irq});
            end
        end
        tbl.delete();
    endtask

    initial begin
        @(negedge clk);

        // Rising capture, edge-driven irq: read latency, W1C, set-over-clear, reset, cs qualification.
        tbl.push_back(mk(1,0,0,0,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'hA5,32'hA5,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'hA5,0));
        tbl.push_back(mk(0,1,1,3,32'hFF,8'hA5,32'hA5,0));
        tbl.push_back(mk(0,1,1,2,32'h01,8'hA4,32'h00,0));
        tbl.push_back(mk(0,0,0,2,32'h0,8'hA4,32'h01,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h01,1));
        tbl.push_back(mk(0,1,1,3,32'h01,8'hA5,32'h01,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA4,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA4,32'h01,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h01,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h01,1));
        tbl.push_back(mk(0,1,1,3,32'h01,8'hA5,32'h01,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h01,1));
        tbl.push_back(mk(0,1,1,3,32'h01,8'hA5,32'h01,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hA5,32'h00,0));
        tbl.push_back(mk(0,1,1,1,32'hFFFFFFFF,8'hA5,32'h00,0));
        tbl.push_back(mk(0,1,1,0,32'hFF,8'hA5,32'hA5,0));
        tbl.push_back(mk(0,0,0,2,32'h0,8'hA5,32'h01,0));
        tbl.push_back(mk(0,1,1,2,32'hFF,8'h00,32'h01,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hFF,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hFF,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hFF,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'hFF,32'hFF,1));
        tbl.push_back(mk(1,0,0,3,32'h0,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h01,32'h01,0));
        tbl.push_back(mk(0,0,0,2,32'h0,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,1,2,32'hFF,8'h01,32'h00,0));
        tbl.push_back(mk(0,0,0,2,32'h0,8'h01,32'h00,0));
        run_table(0, "rise_edgeirq");

        // Any-edge capture with level irq: irq follows data, bit7 pulse captured once, high W1C bits ignored.
        tbl.push_back(mk(1,0,0,0,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,1,1,2,32'h0C,8'h04,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h04,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h04,32'h00,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h04,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h04,1));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h04,0));
        tbl.push_back(mk(0,1,1,3,32'hFF,8'h00,32'h04,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h80,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h80,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h80,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h80,32'h80,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h80,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h80,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h80,0));
        tbl.push_back(mk(0,1,1,3,32'hFFFFFF00,8'h00,32'h80,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h80,0));
        run_table(1, "any_levelirq");

        // No capture, three-stage synchroniser: data latency grows by one, edgecap never sets.
        tbl.push_back(mk(1,0,0,0,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,1,1,2,32'hFF,8'h3C,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'h3C,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'h3C,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'h3C,32'h3C,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,3,32'h0,8'h00,32'h00,0));
        tbl.push_back(mk(0,0,0,0,32'h0,8'h00,32'h00,0));
        run_table(2, "none_sync3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
